// File: rtl/nova_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : nova_mem_arbiter
//  Purpose  : Shares the single-port Nova main memory between the CPU and the
//             data-channel (DMA) port. One registered access per grant. The
//             data channel has priority, and a burst limit makes sure the CPU
//             still gets a slot.
//  Options  : NOVA_ARB_STATS_EN adds per-requester completion counters
//             (cpu_cnt / dch_cnt).
//  Revision : 1.0  initial release
// ============================================================================
module nova_mem_arbiter #(
  parameter int ADDR_W    = 16,
  parameter int DCH_BURST = 4
) (
  input  logic        pclk,
  input  logic        prst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_adr,
  input  logic [15:0] cpu_din,
  output logic        cpu_ack,
  output logic [15:0] cpu_dout,
  input  logic        dch_req,
  input  logic        dch_we,
  input  logic [15:0] dch_adr,
  input  logic [15:0] dch_din,
  output logic        dch_ack,
  output logic [15:0] dch_dout,
  output logic [15:0] mm_adr,
  output logic        mm_we,
  output logic [15:0] mm_din,
  input  logic [15:0] mm_dout,
`ifdef NOVA_ARB_STATS_EN
  output logic [15:0] cpu_cnt,
  output logic [15:0] dch_cnt,
`endif
  output logic        busy
);

  // Keeps only the low ADDR_W address bits; upper port bits read as zero.
  localparam logic [15:0] ADR_MASK  = 16'hFFFF >> (16 - ADDR_W);
  localparam logic [3:0]  BURST_MAX = 4'(DCH_BURST);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic       grant_cpu;
  logic       grant_dch;
  logic       lat_dch;     // owner of the in-flight access (1 = data channel)
  logic       lat_we;      // latched write flag of the in-flight access
  logic [3:0] burst_cnt;   // consecutive DCH grants made while the CPU waited

  assign busy = (state != ST_IDLE);

  // Next-state, arbitration and per-state outputs
  always_comb begin
    state_nxt = state;
    grant_cpu = 1'b0;
    grant_dch = 1'b0;
    cpu_ack   = 1'b0;
    dch_ack   = 1'b0;
    mm_we     = 1'b0;
    case (state)
      ST_IDLE: begin
        // DCH wins unless the CPU has already waited through a full burst.
        if (dch_req && !(cpu_req && (burst_cnt == BURST_MAX))) begin
          grant_dch = 1'b1;
        end else if (cpu_req) begin
          grant_cpu = 1'b1;
        end
        if (grant_dch || grant_cpu) begin
          state_nxt = ST_ACC;
        end
      end
      ST_ACC: begin
        mm_we     = lat_we;
        state_nxt = ST_DONE;
      end
      ST_DONE: begin
        cpu_ack   = ~lat_dch;
        dch_ack   = lat_dch;
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge pclk) begin
    if (!prst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Latch the granted access onto the memory bus and track the DCH burst
  always_ff @(posedge pclk) begin
    if (!prst) begin
      lat_dch   <= 1'b0;
      lat_we    <= 1'b0;
      mm_adr    <= 16'h0000;
      mm_din    <= 16'h0000;
      burst_cnt <= 4'd0;
    end else begin
      if (grant_dch) begin
        lat_dch <= 1'b1;
        lat_we  <= dch_we;
        mm_adr  <= dch_adr & ADR_MASK;
        mm_din  <= dch_din;
      end else if (grant_cpu) begin
        lat_dch <= 1'b0;
        lat_we  <= cpu_we;
        mm_adr  <= cpu_adr & ADR_MASK;
        mm_din  <= cpu_din;
      end
      // The count only moves in IDLE; a CPU grant or an absent CPU request
      // means the CPU is no longer being starved.
      if (state == ST_IDLE) begin
        if (grant_cpu || !cpu_req) begin
          burst_cnt <= 4'd0;
        end else if (grant_dch && (burst_cnt != BURST_MAX)) begin
          burst_cnt <= burst_cnt + 4'd1;
        end
      end
    end
  end

  // Capture read data for the owner on the edge that ends ACC
  always_ff @(posedge pclk) begin
    if (!prst) begin
      cpu_dout <= 16'h0000;
      dch_dout <= 16'h0000;
    end else if ((state == ST_ACC) && !lat_we) begin
      if (lat_dch) begin
        dch_dout <= mm_dout;
      end else begin
        cpu_dout <= mm_dout;
      end
    end
  end

`ifdef NOVA_ARB_STATS_EN
  // Completion counters, one per requester, wrapping at 16 bits
  always_ff @(posedge pclk) begin
    if (!prst) begin
      cpu_cnt <= 16'h0000;
      dch_cnt <= 16'h0000;
    end else begin
      if (cpu_ack) begin
        cpu_cnt <= cpu_cnt + 16'd1;
      end
      if (dch_ack) begin
        dch_cnt <= dch_cnt + 16'd1;
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_nova_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_nova_mem_arbiter
//  Purpose  : Self-checking bench for nova_mem_arbiter: transaction-level
//             reference model plus directed and randomized stimulus.
//  Revision : 1.0  initial release
// ============================================================================
module tb_nova_mem_arbiter;

  localparam int DCH_BURST = 4;

  logic        pclk = 1'b0;
  logic        prst;
  logic        cpu_req, cpu_we, cpu_ack;
  logic [15:0] cpu_adr, cpu_din, cpu_dout;
  logic        dch_req, dch_we, dch_ack;
  logic [15:0] dch_adr, dch_din, dch_dout;
  logic [15:0] mm_adr, mm_din, mm_dout;
  logic        mm_we, busy;
`ifdef NOVA_ARB_STATS_EN
  logic [15:0] cpu_cnt, dch_cnt;
`endif

  logic [15:0] ram     [0:65535];
  logic [15:0] ref_mem [0:65535];

  int checks = 0;
  int errors = 0;

  // Model: an access is "free" (0), in its memory slot (1) or completing (2).
  int          m_phase = 0;
  logic        m_dch, m_we;
  logic [15:0] m_adr, m_din;
  int          m_burst;
  logic [15:0] e_cpu_dout, e_dch_dout, e_mm_adr;
  logic [15:0] m_cpu_cnt, m_dch_cnt;

  bit cmp_en, auto_cpu, auto_dch;
  int cpu_rate, dch_rate;

  always #5 pclk = ~pclk;

  assign mm_dout = ram[mm_adr];

  nova_mem_arbiter #(.ADDR_W(16), .DCH_BURST(DCH_BURST)) dut (
    .pclk(pclk), .prst(prst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_adr(cpu_adr), .cpu_din(cpu_din),
    .cpu_ack(cpu_ack), .cpu_dout(cpu_dout),
    .dch_req(dch_req), .dch_we(dch_we), .dch_adr(dch_adr), .dch_din(dch_din),
    .dch_ack(dch_ack), .dch_dout(dch_dout),
    .mm_adr(mm_adr), .mm_we(mm_we), .mm_din(mm_din), .mm_dout(mm_dout),
`ifdef NOVA_ARB_STATS_EN
    .cpu_cnt(cpu_cnt), .dch_cnt(dch_cnt),
`endif
    .busy(busy)
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] rand_adr();
    logic [15:0] a;
    a = 16'($urandom_range(0, 31));
    if ($urandom_range(0, 3) == 0) a[15:8] = 8'hA5;
    return a;
  endfunction

  task automatic new_cpu();
    cpu_req = 1'b1; cpu_we = 1'($urandom_range(0, 1));
    cpu_adr = rand_adr(); cpu_din = 16'($urandom);
  endtask

  task automatic new_dch();
    dch_req = 1'b1; dch_we = 1'($urandom_range(0, 1));
    dch_adr = rand_adr(); dch_din = 16'($urandom);
  endtask

  // Advance the reference model by one clock edge using the sampled inputs.
  task automatic model_step();
    logic pick_dch;
    if (!prst) begin
      if (m_phase == 1 && m_we) ref_mem[m_adr] = m_din;
      m_phase = 0; m_burst = 0; m_dch = 1'b0; m_we = 1'b0; m_din = 16'h0;
      e_cpu_dout = 16'h0; e_dch_dout = 16'h0; e_mm_adr = 16'h0;
      m_cpu_cnt = 16'h0; m_dch_cnt = 16'h0;
    end else if (m_phase == 1) begin
      if (m_we)       ref_mem[m_adr] = m_din;
      else if (m_dch) e_dch_dout = ref_mem[m_adr];
      else            e_cpu_dout = ref_mem[m_adr];
      m_phase = 2;
    end else if (m_phase == 2) begin
      if (m_dch) m_dch_cnt = m_dch_cnt + 16'd1;
      else       m_cpu_cnt = m_cpu_cnt + 16'd1;
      m_phase = 0;
    end else if (cpu_req || dch_req) begin
      pick_dch = dch_req && !(cpu_req && m_burst >= DCH_BURST);
      if (pick_dch && cpu_req) m_burst = m_burst + 1;
      else                     m_burst = 0;
      m_dch    = pick_dch;
      m_we     = pick_dch ? dch_we  : cpu_we;
      m_adr    = pick_dch ? dch_adr : cpu_adr;
      m_din    = pick_dch ? dch_din : cpu_din;
      e_mm_adr = m_adr;
      m_phase  = 1;
    end else begin
      m_burst = 0;
    end
  endtask

  // Random requesters: hold until own ack, then maybe issue a new access.
  task automatic auto_drive();
    bit ack_c, ack_d;
    ack_c = (m_phase == 2) && !m_dch;
    ack_d = (m_phase == 2) &&  m_dch;
    if (auto_cpu && (ack_c || !cpu_req)) begin
      if (int'($urandom_range(0, 99)) < cpu_rate) new_cpu(); else cpu_req = 1'b0;
    end
    if (auto_dch && (ack_d || !dch_req)) begin
      if (int'($urandom_range(0, 99)) < dch_rate) new_dch(); else dch_req = 1'b0;
    end
  endtask

  task automatic compare_model();
    if (mm_we) ram[mm_adr] = mm_din;
    if (!cmp_en) return;
    chk("busy",     16'(busy),    16'(m_phase != 0));
    chk("mm_we",    16'(mm_we),   16'(m_phase == 1 && m_we));
    chk("cpu_ack",  16'(cpu_ack), 16'(m_phase == 2 && !m_dch));
    chk("dch_ack",  16'(dch_ack), 16'(m_phase == 2 && m_dch));
    chk("ack_excl", 16'(cpu_ack & dch_ack), 16'd0);
    chk("mm_adr",   mm_adr,   e_mm_adr);
    chk("cpu_dout", cpu_dout, e_cpu_dout);
    chk("dch_dout", dch_dout, e_dch_dout);
    if (m_phase == 1) chk("mm_din", mm_din, m_din);
`ifdef NOVA_ARB_STATS_EN
    chk("cpu_cnt", cpu_cnt, m_cpu_cnt);
    chk("dch_cnt", dch_cnt, m_dch_cnt);
`endif
  endtask

  task automatic cycle();
    @(posedge pclk);
    model_step();
    #1;
    auto_drive();
    @(negedge pclk);
    compare_model();
  endtask

  initial begin
    logic  seq [$];
    int    nd, t;
    bit    got;

    for (int i = 0; i < 65536; i++) begin
      ram[i]     = 16'(i * 40503) ^ 16'h5A5A;
      ref_mem[i] = ram[i];
    end
    ram[7] = 16'hBEEF; ref_mem[7] = 16'hBEEF;

    cmp_en = 0; auto_cpu = 0; auto_dch = 0; cpu_rate = 0; dch_rate = 0;
    prst = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_adr = 16'h0010; cpu_din = 16'h0;
    dch_req = 1'b1; dch_we = 1'b0; dch_adr = 16'h0020; dch_din = 16'h0;

    // Reset held two cycles with both requests high
    cycle();
    cmp_en = 1;
    chk("rst_cpu_ack",  16'(cpu_ack), 16'd0);
    chk("rst_dch_ack",  16'(dch_ack), 16'd0);
    chk("rst_mm_we",    16'(mm_we),   16'd0);
    chk("rst_busy",     16'(busy),    16'd0);
    chk("rst_cpu_dout", cpu_dout, 16'h0000);
    chk("rst_dch_dout", dch_dout, 16'h0000);
    chk("rst_mm_adr",   mm_adr,   16'h0000);
    cycle();
    chk("rst2_busy", 16'(busy), 16'd0);
    chk("rst2_ack",  16'(cpu_ack | dch_ack), 16'd0);
    prst = 1'b1;
    cycle();
    chk("rel_busy",   16'(busy), 16'd1);
    chk("rel_mm_adr", mm_adr, 16'h0020);
    auto_cpu = 1; auto_dch = 1;
    repeat (12) cycle();
    auto_cpu = 0; auto_dch = 0;

    // CPU write then read-back of the same word
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_adr = 16'h0100; cpu_din = 16'h1234;
    cycle();
    chk("wr_acc_we",  16'(mm_we), 16'd1);
    chk("wr_acc_adr", mm_adr, 16'h0100);
    chk("wr_acc_din", mm_din, 16'h1234);
    cycle();
    chk("wr_ack",     16'(cpu_ack), 16'd1);
    chk("wr_done_we", 16'(mm_we),   16'd0);
    cpu_we = 1'b0;
    cycle();
    chk("rd_idle_busy", 16'(busy),  16'd0);
    chk("rd_idle_we",   16'(mm_we), 16'd0);
    cycle();
    chk("rd_acc_we", 16'(mm_we), 16'd0);
    cycle();
    chk("rd_ack",  16'(cpu_ack), 16'd1);
    chk("rd_data", cpu_dout, 16'h1234);
    cpu_req = 1'b0;
    cycle();
    chk("rd_ack_pulse", 16'(cpu_ack), 16'd0);

    // DCH read of a preloaded word
    dch_req = 1'b1; dch_we = 1'b0; dch_adr = 16'h0007;
    cycle();
    chk("dch_acc_adr", mm_adr, 16'h0007);
    cycle();
    chk("dch_ack",     16'(dch_ack), 16'd1);
    chk("dch_data",    dch_dout, 16'hBEEF);
    chk("dch_cpu_ack", 16'(cpu_ack), 16'd0);
    dch_req = 1'b0;
    cycle();
    chk("dch_ack_pulse", 16'(dch_ack), 16'd0);
    repeat (2) cycle();

    // Both requesting continuously: D,D,D,D,C repeating
    cpu_rate = 100; dch_rate = 100; auto_cpu = 1; auto_dch = 1;
    new_cpu(); new_dch();
    t = 0;
    while (seq.size() < 20 && t < 200) begin
      cycle(); t++;
      if (cpu_ack) seq.push_back(1'b1);
      if (dch_ack) seq.push_back(1'b0);
    end
    chk("burst_grants_seen", 16'(seq.size() >= 20), 16'd1);
    for (int i = 0; i < 20 && i < seq.size(); i++)
      chk("burst_order", 16'(seq[i]), 16'(i % 5 == 4));
    cpu_rate = 0; dch_rate = 0;
    repeat (10) cycle();

    // CPU withdraws after two DCH grants, then returns: count restarts
    auto_cpu = 0; auto_dch = 1; dch_rate = 100;
    new_dch();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_adr = 16'h0005;
    nd = 0; t = 0;
    while (nd < 2 && t < 100) begin cycle(); t++; if (dch_ack) nd++; end
    cpu_req = 1'b0;
    while (nd < 3 && t < 100) begin cycle(); t++; if (dch_ack) nd++; end
    chk("drop_dch_grants", 16'(nd), 16'd3);
    cpu_req = 1'b1; cpu_adr = 16'h0006;
    nd = 0; got = 0; t = 0;
    while (!got && t < 100) begin
      cycle(); t++;
      if (dch_ack) nd++;
      if (cpu_ack) got = 1;
    end
    chk("reassert_cpu_served", 16'(got), 16'd1);
    chk("reassert_dch_first",  16'(nd),  16'd4);
    cpu_req = 1'b0; dch_rate = 0;
    repeat (10) cycle();

    // Randomized traffic at varying request rates
    auto_cpu = 1; auto_dch = 1;
    for (int s = 0; s < 6; s++) begin
      cpu_rate = int'($urandom_range(20, 90));
      dch_rate = int'($urandom_range(20, 90));
      repeat (300) cycle();
    end
    cpu_rate = 0; dch_rate = 0;
    repeat (10) cycle();
    auto_cpu = 0; auto_dch = 0;

    // Reset asserted during the memory slot of a CPU write
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_adr = 16'h0200; cpu_din = 16'hCAFE;
    cycle();
    chk("rstacc_we", 16'(mm_we), 16'd1);
    prst = 1'b0;
    cycle();
    chk("rstacc_busy",   16'(busy),    16'd0);
    chk("rstacc_ack",    16'(cpu_ack), 16'd0);
    chk("rstacc_mm_adr", mm_adr, 16'h0000);
    prst = 1'b1; cpu_req = 1'b0;
    cycle();
    chk("rstacc_ack2", 16'(cpu_ack), 16'd0);
    repeat (3) cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
